// File: rtl/uart_frame_assembler.sv
// Rebuilds 17-bit samples from the tagged LOW/MID/HIGH UART byte stream.
// Optional partial-frame timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
   parameter int INPUT_CLOCK_FREQ = 200_000_000,
   parameter int BAUD_RATE        = 115200,
   parameter int TIMEOUT_BYTES    = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid_in,
   output logic [16:0] data_out,
   output logic        data_valid_out,
   output logic        frame_error_out,
   output logic [7:0]  frames_dropped_out
);

   typedef enum logic [1:0] {WAIT_LOW, WAIT_MID, WAIT_HIGH} state_t;
   typedef enum logic [1:0] {T_LOW, T_MID, T_HIGH, T_BAD} tag_t;

   state_t     state_q, state_d;
   tag_t       tag;
   logic [5:0] low_q, mid_q;
   logic       ld_low, ld_mid, vld_d, err_d;
   logic       timeout_hit;

   always_comb begin
      tag = T_BAD;
      case (byte_in[7:6])
         2'b00:   tag = T_LOW;
         2'b01:   tag = T_MID;
         2'b10:   tag = byte_in[5] ? T_BAD : T_HIGH;
         default: tag = T_BAD;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= WAIT_LOW;
      else        state_q <= state_d;
   end

   // A LOW byte always (re)starts a frame, whatever state we are in.
   always_comb begin
      state_d = state_q;
      if (byte_valid_in) begin
         case (state_q)
            WAIT_LOW:  state_d = (tag == T_LOW) ? WAIT_MID : WAIT_LOW;
            WAIT_MID:  state_d = (tag == T_LOW) ? WAIT_MID :
                                 (tag == T_MID) ? WAIT_HIGH : WAIT_LOW;
            WAIT_HIGH: state_d = (tag == T_LOW) ? WAIT_MID : WAIT_LOW;
            default:   state_d = WAIT_LOW;
         endcase
      end else if (timeout_hit) begin
         state_d = WAIT_LOW;
      end
   end

   always_comb begin
      ld_low = byte_valid_in && (tag == T_LOW);
      ld_mid = byte_valid_in && (state_q == WAIT_MID) && (tag == T_MID);
      vld_d  = byte_valid_in && (state_q == WAIT_HIGH) && (tag == T_HIGH);
      err_d  = timeout_hit;
      if (byte_valid_in)
         err_d = !(((state_q == WAIT_LOW) && (tag == T_LOW)) || ld_mid || vld_d);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         low_q              <= '0;
         mid_q              <= '0;
         data_out           <= '0;
         data_valid_out     <= 1'b0;
         frame_error_out    <= 1'b0;
         frames_dropped_out <= '0;
      end else begin
         data_valid_out  <= vld_d;
         frame_error_out <= err_d;
         if (ld_low) low_q <= byte_in[5:0];
         if (ld_mid) mid_q <= byte_in[5:0];
         if (vld_d)  data_out <= {byte_in[4:0], mid_q, low_q};
         if (err_d && frames_dropped_out != 8'hFF)
            frames_dropped_out <= frames_dropped_out + 8'd1;
      end
   end

`ifdef FRAME_TIMEOUT_EN
   localparam longint TO_CYCLES = longint'(TIMEOUT_BYTES) * 10 * longint'(INPUT_CLOCK_FREQ)
                                  / longint'(BAUD_RATE);
   localparam int     TO_W      = $clog2(TO_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;

   // Counts idle cycles since the last accepted byte of a partial frame.
   always_ff @(posedge clk_in) begin
      if (rst_in || byte_valid_in || timeout_hit || state_q == WAIT_LOW)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout_hit = (state_q != WAIT_LOW) && (to_cnt == TO_W'(TO_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Receive-side framing stage that rebuilds 17-bit samples from the tagged 3-byte UART stream produced by the transmit wrapper. It sits directly downstream of the byte-level UART receiver and consumes one byte per `byte_valid_in` pulse. It emits each complete sample as a one-cycle valid pulse. It detects out-of-order or malformed bytes, resynchronises on them, and keeps a count of dropped frames.

## Interface
- `INPUT_CLOCK_FREQ`, default 200_000_000: clock frequency in Hz; used only for the timeout.
- `BAUD_RATE`, default 115200: line rate; used only for the timeout.
- `TIMEOUT_BYTES`, default 4: partial-frame timeout, in byte-times (10 bits each).
- `clk_in`  input  1: the block's single clock.
- `rst_in`  input  1: synchronous, active-high reset.
- `byte_in`  input  8: received byte; valid only when `byte_valid_in` = 1.
- `byte_valid_in`  input  1: single-cycle strobe per received byte; no backpressure.
- `data_out`  output  17: last assembled sample; held until the next frame completes.
- `data_valid_out`  output  1: one-cycle pulse when `data_out` updates.
- `frame_error_out`  output  1: one-cycle pulse per dropped or aborted frame.
- `frames_dropped_out`  output  8: saturating count of `frame_error_out` pulses.

## Operation
- Tag decode of `byte_in`:
  - bits [7:6] = 00 → LOW, payload [5:0].
  - bits [7:6] = 01 → MID, payload [5:0].
  - bits [7:5] = 100 → HIGH, payload [4:0].
  - bits [7:5] = 101 or bits [7:6] = 11 → BAD.
- Registers: `low_q[5:0]`, `mid_q[5:0]`, state.
- States, reset state WAIT_LOW. Transitions apply only on cycles with `byte_valid_in`.
- WAIT_LOW:
  - LOW → store `low_q`, go to WAIT_MID.
  - MID/HIGH/BAD → error pulse, stay in WAIT_LOW.
- WAIT_MID:
  - MID → store `mid_q`, go to WAIT_HIGH.
  - LOW → error pulse, store as new `low_q` (resync), stay in WAIT_MID.
  - HIGH/BAD → error pulse, go to WAIT_LOW.
- WAIT_HIGH:
  - HIGH → `data_out` <= {payload[4:0], `mid_q`, `low_q`}, `data_valid_out` <= 1, go to WAIT_LOW.
  - LOW → error pulse, store `low_q`, go to WAIT_MID.
  - MID/BAD → error pulse, go to WAIT_LOW.
- `frames_dropped_out` increments by 1 on every error pulse and saturates at 255 (no wrap).
- `data_valid_out` and `frame_error_out` are never asserted in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, including `data_out`.
- Reset on any cycle, including mid-frame, discards the partial frame and returns to WAIT_LOW. It does not generate an error pulse or a count increment.
- Valid pulse latency: `data_valid_out` = 1 in the cycle after the cycle where the HIGH byte is presented.
- Error pulse latency: `frame_error_out` = 1 in the cycle after the offending byte.
- Back-to-back `byte_valid_in` on consecutive cycles is supported at full rate with no lost bytes.
- Pulses last exactly one cycle unless the next byte causes another pulse.

## Configuration
- Macro `FRAME_TIMEOUT_EN`.
- Defined:
  - A counter runs while in WAIT_MID or WAIT_HIGH. It clears on every accepted byte and on entering WAIT_LOW.
  - When it reaches `TIMEOUT_BYTES*10*INPUT_CLOCK_FREQ/BAUD_RATE` cycles: error pulse, count increment, return to WAIT_LOW.
  - If `byte_valid_in` arrives in the same cycle as expiry, the byte is processed normally and the timeout is ignored.
- Undefined: no counter; a partial frame waits indefinitely.

## Test plan
- Bytes 0x0D, 0x6F, 0x9A, spaced 3 cycles apart → one `data_valid_out` pulse with `data_out` = 0x1ABCD; no error; count = 0.
- Back-to-back bytes 0x3F, 0x7F, 0x9F, then 0x00, 0x40, 0x80 → `data_out` = 0x1FFFF, then 0x00000; exactly two valid pulses.
- Bytes 0x0D, 0x0A, 0x6F, 0x9A → one error pulse on 0x0A; the 0x0A byte is taken as the new LOW (resync); `data_out` = 0x1ABCA; count = 1.
- Bytes 0x9A, 0xC0, 0xA5, then 0x0D, 0x6F, 0x9A → three error pulses, then `data_out` = 0x1ABCD.
- 300 stray 0xFF bytes → count saturates at 255; `rst_in` mid-frame after 0x0D, 0x6F → all outputs 0 and the following 0x9A counts as an error.
- With `FRAME_TIMEOUT_EN` and parameters 100 MHz, 1 Mbaud, `TIMEOUT_BYTES` = 4 (400 cycles): byte 0x0D, then idle 400 cycles → error pulse.
- Same configuration: byte 0x0D, then 0x6F at cycle 399 and 0x9A shortly after → valid frame, no error.
